// File: rtl/corescore_mmcm_drp_ctrl_if.sv
// corescore_mmcm_drp_ctrl_if: DRP bus between the reconfiguration sequencer and the MMCM
interface corescore_mmcm_drp_ctrl_if;
  logic        den;
  logic        dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;
  modport master (output den, dwe, daddr, di, input dout, drdy);
  modport slave (input den, dwe, daddr, di, output dout, drdy);
endinterface

// File: rtl/corescore_mmcm_drp_ctrl.sv
// corescore_mmcm_drp_ctrl: MMCM DRP read-modify-write sequencer with lock-gated core reset
module corescore_mmcm_drp_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int RST_HOLD = 16,
  parameter int TIMEOUT = 65535,
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CW = $clog2(((RST_HOLD > TIMEOUT) ? RST_HOLD : TIMEOUT) + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  output logic [IW-1:0]                  o_tab_idx,
  input  logic [6:0]                     i_tab_addr,
  input  logic [15:0]                    i_tab_mask,
  input  logic [15:0]                    i_tab_data,
  corescore_mmcm_drp_ctrl_if.master      drp,
  input  logic                           i_locked,
  output logic                           o_mmcm_rst,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err,
  output logic                           o_rst
);
  typedef enum logic [3:0] {IDLE, HOLD, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK, DONE} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]  idx_q, idx_d;
  logic           den_q, den_d, dwe_q, dwe_d;
  logic [6:0]     daddr_q, daddr_d;
  logic [15:0]    di_q, di_d;
  logic           mrst_q, mrst_d, err_q, err_d, rst_q;
  logic [1:0]     lock_q;
  logic           locked_s, tmo;
  assign locked_s = lock_q[1];
  assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
  assign tmo = cnt_q >= CW'(TIMEOUT - 1);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      daddr_q <= '0;
      di_q    <= '0;
      mrst_q  <= 1'b0;
      err_q   <= 1'b0;
      rst_q   <= 1'b1;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      den_q   <= den_d;
      dwe_q   <= dwe_d;
      daddr_q <= daddr_d;
      di_q    <= di_d;
      mrst_q  <= mrst_d;
      err_q   <= err_d;
      rst_q   <= !locked_s | mrst_q;
      lock_q  <= {lock_q[0], i_locked};
    end
  end
  // Every wait state aborts the same way on timeout: flag error, free the MMCM, go idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    den_d   = 1'b0;
    dwe_d   = 1'b0;
    daddr_d = daddr_q;
    di_d    = di_q;
    mrst_d  = mrst_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (i_start) begin
        state_d = HOLD;
        mrst_d  = 1'b1;
        idx_d   = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      HOLD: begin
        state_d = (cnt_q >= CW'(RST_HOLD - 1)) ? RD : HOLD;
        cnt_d   = (cnt_q >= CW'(RST_HOLD - 1)) ? '0 : cnt_q + CW'(1);
      end
      RD: begin
        den_d   = 1'b1;
        daddr_d = i_tab_addr;
        cnt_d   = '0;
        state_d = WAIT_RD;
      end
      WR: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_WR;
      end
      WAIT_RD, WAIT_WR, WAIT_LOCK: begin
        if (state_q == WAIT_LOCK ? locked_s : drp.drdy) begin
          di_d    = (state_q == WAIT_RD) ? (drp.dout & i_tab_mask) | i_tab_data : di_q;
          idx_d   = (state_q == WAIT_WR && idx_q != IW'(NUM_REGS - 1)) ? idx_q + IW'(1) : idx_q;
          state_d = (state_q == WAIT_RD) ? WR :
                    (state_q == WAIT_LOCK) ? DONE :
                    (idx_q == IW'(NUM_REGS - 1)) ? RELEASE : RD;
        end else if (tmo) begin
          err_d   = 1'b1;
          mrst_d  = 1'b0;
          state_d = IDLE;
        end else
          cnt_d = cnt_inc;
      end
      RELEASE: begin
        mrst_d  = 1'b0;
        cnt_d   = '0;
        state_d = WAIT_LOCK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state_q != IDLE;
    o_done = state_q == DONE;
  end
  assign o_tab_idx  = idx_q;
  assign drp.den    = den_q;
  assign drp.dwe    = dwe_q;
  assign drp.daddr  = daddr_q;
  assign drp.di     = di_q;
  assign o_mmcm_rst = mrst_q;
  assign o_err      = err_q;
  assign o_rst      = rst_q;
endmodule

// File: tb/tb_corescore_mmcm_drp_ctrl.sv
// tb_corescore_mmcm_drp_ctrl: randomized DRP/lock scenarios against a register-file model
module tb_corescore_mmcm_drp_ctrl;
  localparam int NR = 4;
  localparam int HOLD = 16;
  localparam int TMO = 120;
  typedef struct packed {logic we; logic [6:0] a; logic [15:0] d;} acc_t;
  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_locked;
  logic [1:0]  o_tab_idx;
  logic [6:0]  i_tab_addr;
  logic [15:0] i_tab_mask, i_tab_data;
  logic        o_mmcm_rst, o_busy, o_done, o_err, o_rst;
  logic [6:0]  t_addr [NR];
  logic [15:0] t_mask [NR];
  logic [15:0] t_data [NR];
  logic [15:0] mem [128];
  acc_t        log_q [$];
  bit          drop_en, ovl;
  int          drop_idx, acc_n;
  int          cmp, fail;
  corescore_mmcm_drp_ctrl_if drp ();
  corescore_mmcm_drp_ctrl #(.NUM_REGS(NR), .RST_HOLD(HOLD), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_tab_idx(o_tab_idx),
    .i_tab_addr(i_tab_addr), .i_tab_mask(i_tab_mask), .i_tab_data(i_tab_data),
    .drp(drp), .i_locked(i_locked), .o_mmcm_rst(o_mmcm_rst), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_rst(o_rst));
  assign i_tab_addr = t_addr[o_tab_idx];
  assign i_tab_mask = t_mask[o_tab_idx];
  assign i_tab_data = t_data[o_tab_idx];
  always #5 i_clk = ~i_clk;
  // DRP slave: answers 3 cycles after den, reads return the pre-write register value
  initial begin
    drp.drdy = 1'b0;
    drp.dout = '0;
    forever begin
      @(negedge i_clk);
      if (drp.den) begin
        log_q.push_back({drp.dwe, drp.daddr, drp.di});
        acc_n++;
        if (!(drop_en && acc_n - 1 == drop_idx)) begin
          drp.dout = mem[drp.daddr];
          if (drp.dwe) mem[drp.daddr] = drp.di;
          repeat (2) begin
            @(negedge i_clk);
            if (drp.den) ovl = 1'b1;
          end
          drp.drdy = 1'b1;
          @(negedge i_clk);
          drp.drdy = 1'b0;
        end
      end
    end
  end
  task automatic pulse_start;
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
  endtask
  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b0; i_locked = 1'b0;
    repeat (3) @(negedge i_clk);
    cmp++;
    if ({o_rst, o_mmcm_rst, o_busy, drp.den, o_done, o_err} !== 6'b100000) begin
      fail++; $display("FAIL reset_outputs got %b want 100000", {o_rst, o_mmcm_rst, o_busy, drp.den, o_done, o_err});
    end
    cmp++;
    if (o_tab_idx !== 2'd0) begin fail++; $display("FAIL reset_idx got %0d want 0", o_tab_idx); end
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    cmp++;
    if (o_busy !== 1'b0) begin fail++; $display("FAIL idle_after_reset busy=%b want 0", o_busy); end
  endtask
  // Runs one full DRP table rewrite and compares the access log against the table rules
  task automatic test_drp_sequence(input bit fixed);
    logic [15:0] em [128];
    logic [15:0] w;
    int hold, n;
    i_locked = 1'b0;
    for (int i = 0; i < NR; i++) begin
      t_addr[i] = fixed ? 7'(i * 5 + 3) : 7'($urandom_range(0, 127));
      t_mask[i] = fixed ? 16'hF000 : 16'($urandom);
      t_data[i] = fixed ? 16'h0123 : 16'($urandom);
    end
    if (fixed) for (int a = 0; a < 128; a++) mem[a] = 16'hA5A5;
    em = mem;
    log_q.delete(); acc_n = 0; ovl = 1'b0;
    pulse_start();
    hold = 0; n = 0;
    while (!drp.den && n < 200) begin
      if (o_mmcm_rst) hold++;
      @(negedge i_clk); n++;
    end
    cmp++;
    if (!(drp.den === 1'b1 && hold >= HOLD)) begin
      fail++; $display("FAIL rst_hold den=%b held %0d want >=%0d", drp.den, hold, HOLD);
    end
    n = 0;
    while (o_mmcm_rst && n < 2000) begin @(negedge i_clk); n++; end
    cmp++;
    if (o_mmcm_rst !== 1'b0) begin fail++; $display("FAIL release mmcm_rst=%b want 0", o_mmcm_rst); end
    cmp++;
    if (log_q.size() != 2 * NR) begin fail++; $display("FAIL access_count got %0d want %0d", log_q.size(), 2 * NR); end
    for (int i = 0; i < NR && log_q.size() > 2 * i + 1; i++) begin
      w = (em[t_addr[i]] & t_mask[i]) | t_data[i];
      em[t_addr[i]] = w;
      cmp++;
      if ({log_q[2*i].we, log_q[2*i].a} !== {1'b0, t_addr[i]}) begin
        fail++; $display("FAIL read%0d got we=%b addr=%h want we=0 addr=%h", i, log_q[2*i].we, log_q[2*i].a, t_addr[i]);
      end
      cmp++;
      if (log_q[2*i+1] !== {1'b1, t_addr[i], w}) begin
        fail++; $display("FAIL write%0d got %h want %h", i, log_q[2*i+1], {1'b1, t_addr[i], w});
      end
      if (fixed) begin
        cmp++;
        if (log_q[2*i+1].d !== 16'hA123) begin fail++; $display("FAIL fixed_di%0d got %h want A123", i, log_q[2*i+1].d); end
      end
    end
    cmp++;
    if (ovl) begin fail++; $display("FAIL den_overlap got 1 want 0"); end
  endtask
  task automatic test_lock(input int dly);
    int n, dcnt;
    bit stay;
    dcnt = 0; stay = 1'b1;
    repeat (dly - 1) begin
      @(negedge i_clk);
      dcnt += int'(o_done);
      stay &= o_busy & o_rst;
    end
    i_locked = 1'b1;
    n = 0;
    while (o_rst === 1'b1 && n < 10) begin @(negedge i_clk); n++; dcnt += int'(o_done); end
    cmp++;
    if (!stay) begin fail++; $display("FAIL lock_wait busy/rst dropped early got 0 want 1"); end
    cmp++;
    if (n != 3 || o_done !== 1'b1) begin fail++; $display("FAIL rst_release cycles=%0d done=%b want 3 and 1", n, o_done); end
    repeat (5) begin @(negedge i_clk); dcnt += int'(o_done); end
    cmp++;
    if ({dcnt == 1, o_busy, o_err, o_rst} !== 4'b1000) begin
      fail++; $display("FAIL done_pulse count=%0d busy=%b err=%b rst=%b want 1,0,0,0", dcnt, o_busy, o_err, o_rst);
    end
  endtask
  task automatic test_lock_timeout;
    int n, dn;
    test_drp_sequence(1'b0);
    n = 0; dn = 0;
    while (!o_err && n < TMO + 20) begin @(negedge i_clk); n++; dn += int'(o_done); end
    cmp++;
    if (n != TMO) begin fail++; $display("FAIL lock_timeout cycles=%0d want %0d", n, TMO); end
    cmp++;
    if ({o_busy, o_mmcm_rst, dn != 0, o_rst} !== 4'b0001) begin
      fail++; $display("FAIL lock_abort busy=%b mmcm_rst=%b dones=%0d rst=%b want 0,0,0,1", o_busy, o_mmcm_rst, dn, o_rst);
    end
    pulse_start();
    cmp++;
    if ({o_err, o_busy} !== 2'b01) begin fail++; $display("FAIL err_clear err=%b busy=%b want 0,1", o_err, o_busy); end
    @(negedge i_clk) i_rst = 1'b1;
    @(negedge i_clk) i_rst = 1'b0;
  endtask
  task automatic test_drp_timeout;
    int n, nd;
    i_locked = 1'b0;
    for (int i = 0; i < NR; i++) begin
      t_addr[i] = 7'($urandom_range(0, 127)); t_mask[i] = 16'($urandom); t_data[i] = 16'($urandom);
    end
    log_q.delete(); acc_n = 0; drop_en = 1'b1; drop_idx = 2;
    pulse_start();
    n = 0; nd = 0;
    while (nd < 3 && n < 500) begin @(negedge i_clk); nd += int'(drp.den); n++; end
    n = 0;
    while (!o_err && n < TMO + 20) begin @(negedge i_clk); n++; end
    cmp++;
    if (n != TMO) begin fail++; $display("FAIL drdy_timeout cycles=%0d want %0d", n, TMO); end
    cmp++;
    if ({o_tab_idx, o_busy, o_mmcm_rst, o_done} !== 5'b01000) begin
      fail++; $display("FAIL drdy_abort idx=%0d busy=%b mmcm_rst=%b done=%b want 1,0,0,0", o_tab_idx, o_busy, o_mmcm_rst, o_done);
    end
    drop_en = 1'b0;
    repeat (8) @(negedge i_clk);
  endtask
  task automatic test_back_to_back;
    int n;
    i_locked = 1'b0;
    for (int i = 0; i < NR; i++) begin
      t_addr[i] = 7'($urandom_range(0, 127)); t_mask[i] = 16'($urandom); t_data[i] = 16'($urandom);
    end
    log_q.delete(); acc_n = 0;
    pulse_start();
    n = 0;
    while (!(drp.den && drp.dwe) && n < 500) begin @(negedge i_clk); n++; end
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    n = 0;
    while (o_mmcm_rst && n < 2000) begin @(negedge i_clk); n++; end
    cmp++;
    if (log_q.size() != 2 * NR || o_mmcm_rst !== 1'b0) begin
      fail++; $display("FAIL start_dropped accesses=%0d mmcm_rst=%b want %0d,0", log_q.size(), o_mmcm_rst, 2 * NR);
    end
    repeat (10) @(negedge i_clk);
    i_locked = 1'b1; i_rst = 1'b1;
    @(negedge i_clk);
    cmp++;
    if ({o_rst, o_mmcm_rst, o_busy, o_done, o_err, drp.den, drp.dwe, drp.daddr, drp.di, o_tab_idx} !== {6'b100000, 1'b0, 7'd0, 16'd0, 2'd0}) begin
      fail++; $display("FAIL midlock_reset got %b %h %h idx=%0d want 1000000 0 0 0",
        {o_rst, o_mmcm_rst, o_busy, o_done, o_err, drp.den, drp.dwe}, drp.daddr, drp.di, o_tab_idx);
    end
    i_rst = 1'b0; i_locked = 1'b0; n = 0;
    repeat (20) begin @(negedge i_clk); n += int'(o_busy | drp.den); end
    cmp++;
    if (n != 0) begin fail++; $display("FAIL no_requeue busy/den cycles=%0d want 0", n); end
  endtask
  initial begin
    cmp = 0; fail = 0; drop_en = 1'b0; drop_idx = 0; acc_n = 0; ovl = 1'b0;
    for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
    test_reset();
    test_drp_sequence(1'b1);
    test_lock(100);
    for (int k = 0; k < 3; k++) begin
      test_drp_sequence(1'b0);
      test_lock(int'($urandom_range(4, 100)));
    end
    test_lock_timeout();
    test_drp_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
    $finish;
  end
endmodule
